// File: rtl/niosballe_pio_in.sv
// Avalon-MM input PIO: synchronises game-board inputs, captures edges into sticky bits, raises a maskable irq.
// Optional per-bit debounce filter is compiled in with `define PIO_IN_DEBOUNCE_EN.
module niosballe_pio_in #(
  parameter int WIDTH           = 9,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] r_sync1, r_sync2, r_d_prev;
  logic [WIDTH-1:0] r_irqmask, r_edgecap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_filtered, w_rise, w_fall, w_edge, w_clr;
  logic [31:0]      w_rdata;
  logic             w_wr, w_rd;
  logic             w_unused_wdata;

  assign w_wr           = chipselect && !write_n;
  assign w_rd           = chipselect && !read_n;
  assign w_unused_wdata = ^writedata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_filtered;

  // A bit only changes after sync2 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filtered <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_filtered[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filtered[i] <= r_sync2[i];
          r_cnt[i]      <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_filtered = r_filtered;
`else
  localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;
  assign w_filtered = r_sync2;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rise = w_filtered & ~r_d_prev;
    w_fall = ~w_filtered & r_d_prev;
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise | w_fall;
    endcase
  end

  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_filtered;
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_prev   <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_d_prev <= w_filtered;
      if (w_wr && (address == ADDR_IRQMASK)) r_irqmask <= writedata[WIDTH-1:0];
      // New edges are OR-ed in after the clear so a coincident event is never lost.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_rd) r_readdata <= w_rdata;
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_niosballe_pio_in.sv
// Scoreboard bench for niosballe_pio_in: one rising-edge instance and one any-edge instance on a shared bus.
module tb_niosballe_pio_in;

  localparam int WIDTH = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             read_n = 1'b1;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '0;
  logic [31:0]      readdata, readdata_any;
  logic             irq, irq_any;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] exp_any;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  logic      rd_seen = 1'b0;

  always #5 clk = ~clk;

  niosballe_pio_in #(.WIDTH(WIDTH), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  niosballe_pio_in #(.WIDTH(WIDTH), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_any), .in_port(in_port), .irq(irq_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Read data is due on the edge after the strobe; compare it on the following falling edge.
  always @(posedge clk) rd_seen <= chipselect && !read_n && !reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check(e.tag, readdata, e.exp);
        check({e.tag, "_any"}, readdata_any, e.exp_any);
      end
    end
  end

  // All tasks start and end on a falling edge, so back-to-back calls keep strobes continuous.
  task automatic bus_read(input logic [1:0] a, input string tag,
                          input logic [31:0] exp, input logic [31:0] exp_any);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    sb_q.push_back('{tag, exp, exp_any});
    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    pulse_reset();
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, "rst_data", 32'h0, 32'h0);
    bus_read(2'd2, "rst_mask", 32'h0, 32'h0);
    bus_read(2'd3, "rst_ecap", 32'h0, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
    // 5-cycle pulse is shorter than the 8-cycle filter.
    in_port = 9'h001;
    idle(5);
    in_port = 9'h000;
    idle(12);
    bus_read(2'd0, "db_pulse_data", 32'h0, 32'h0);
    bus_read(2'd3, "db_pulse_ecap", 32'h0, 32'h0);

    // Stable level: filtered flips on the 10th edge after the change.
    in_port = 9'h001;
    idle(9);
    bus_read(2'd0, "db_lvl_early", 32'h0, 32'h0);
    bus_read(2'd0, "db_lvl_data", 32'h1, 32'h1);
    bus_read(2'd3, "db_lvl_ecap", 32'h1, 32'h1);

    // Reset while the falling transition is mid-count.
    in_port = 9'h000;
    idle(4);
    pulse_reset();
    bus_read(2'd0, "db_rst_data", 32'h0, 32'h0);
    bus_read(2'd3, "db_rst_ecap", 32'h0, 32'h0);

    in_port = 9'h001;
    idle(9);
    bus_read(2'd0, "db_post_early", 32'h0, 32'h0);
    bus_read(2'd0, "db_post_data", 32'h1, 32'h1);
`else
    // Rising edges on bits 0 and 2: DATA after 2 edges, EDGECAP set on the 3rd.
    in_port = 9'h005;
    bus_read(2'd0, "lat_data0", 32'h0, 32'h0);
    bus_read(2'd0, "lat_data1", 32'h0, 32'h0);
    bus_read(2'd3, "lat_ecap2", 32'h0, 32'h0);
    bus_read(2'd3, "lat_ecap3", 32'h5, 32'h5);
    bus_read(2'd0, "lat_data", 32'h5, 32'h5);
    check("irq_masked", {31'b0, irq}, 32'h0);
    check("irq_masked_any", {31'b0, irq_any}, 32'h0);

    bus_write(2'd2, 32'h004);
    check("irq_mask_lat", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_mask_on", {31'b0, irq}, 32'h1);
    check("irq_mask_on_any", {31'b0, irq_any}, 32'h1);
    bus_read(2'd2, "mask_rd", 32'h4, 32'h4);

    bus_write(2'd3, 32'h004);
    check("irq_clr_lat", {31'b0, irq}, 32'h1);
    idle(1);
    check("irq_clr_off", {31'b0, irq}, 32'h0);
    bus_read(2'd3, "ecap_w1c", 32'h1, 32'h1);

    // Falls are captured only by the any-edge instance.
    in_port = 9'h000;
    idle(4);
    bus_read(2'd3, "fall_ecap", 32'h1, 32'h5);
    bus_write(2'd3, 32'h1ff);
    in_port = 9'h001;
    idle(4);
    bus_read(2'd3, "pre_race", 32'h1, 32'h1);

    // Bit 2 rises on the same edge its clear lands; bit 0 clears normally.
    in_port = 9'h005;
    idle(2);
    bus_write(2'd3, 32'h005);
    bus_read(2'd3, "race_set_wins", 32'h4, 32'h4);
    check("race_irq", {31'b0, irq}, 32'h1);
    check("race_irq_any", {31'b0, irq_any}, 32'h1);

    // Bit 8 toggles 0 -> 1 -> 0.
    bus_write(2'd3, 32'h1ff);
    in_port = 9'h105;
    idle(4);
    bus_read(2'd3, "b8_rise", 32'h100, 32'h100);
    bus_write(2'd3, 32'h100);
    in_port = 9'h005;
    idle(4);
    bus_read(2'd3, "b8_fall", 32'h0, 32'h100);
    check("b8_irq", {31'b0, irq}, 32'h0);
    check("b8_irq_any", {31'b0, irq_any}, 32'h0);

    // DATA and reserved writes are ignored; bits above WIDTH are dropped.
    bus_write(2'd0, 32'hffff_ffff);
    bus_write(2'd1, 32'hffff_ffff);
    bus_read(2'd0, "ro_data", 32'h5, 32'h5);
    bus_read(2'd1, "rsvd", 32'h0, 32'h0);
    bus_read(2'd2, "ro_mask", 32'h4, 32'h4);
    bus_read(2'd3, "ro_ecap", 32'h0, 32'h100);
    bus_write(2'd2, 32'hffff_fe03);
    bus_read(2'd2, "mask_width", 32'h3, 32'h3);

    bus_read(2'd0, "hold_src", 32'h5, 32'h5);
    idle(1);
    check("rd_hold", readdata, 32'h5);
    check("rd_hold_any", readdata_any, 32'h5);

    // Reset with inputs in flight, then legitimate rising edges after release.
    in_port = 9'h1ff;
    idle(2);
    pulse_reset();
    check("mid_rst_readdata", readdata, 32'h0);
    check("mid_rst_irq", {31'b0, irq_any}, 32'h0);
    bus_read(2'd3, "mid_rst_ecap", 32'h0, 32'h0);
    bus_read(2'd2, "mid_rst_mask", 32'h0, 32'h0);
    bus_read(2'd0, "post_rst_data", 32'h1ff, 32'h1ff);
    bus_read(2'd3, "post_rst_ecap", 32'h1ff, 32'h1ff);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
`endif

    idle(2);
    check("sb_drain", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
